pipe_regs: RTL and testbench
============================

# pipe_regs

Parametrised multi-stage pipeline register with per-stage valid bits, stall and flush, the successor of the single-stage resettable flip-flop `flopr`. It carries an N-bit word through DEPTH register stages. It sits between the stages of the pipelined processor, for example IF/ID, ID/EX, EX/MEM and MEM/WB. Stall holds every stage, flush converts every in-flight entry into a bubble, and an occupancy counter reports how many valid entries are in flight.

## Interface
- `N`, default 64: data width in bits (≥1).
- `DEPTH`, default 1: number of register stages (≥1); latency in enabled cycles.
- `ZERO_BUBBLES`, default 1: 1 means a stage written with valid=0 stores all-zero data; 0 means it stores `d` unchanged.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  advance enable; 0 means stall (all stages hold).
- `flush`  in  1  clear all stages to bubbles; has priority over `en`.
- `d`  in  N  input word.
- `d_valid`  in  1  `d` carries a valid entry.
- `q`  out  N  word in the last stage.
- `q_valid`  out  1  valid bit of the last stage.
- `occ`  out  $clog2(DEPTH+1)  registered count of valid stages, 0..DEPTH.

## Operation
- State: data registers `s[0..DEPTH-1]` (N bits each), valid bits `v[0..DEPTH-1]`, and the counter `occ`.
- Outputs: `q = s[DEPTH-1]` and `q_valid = v[DEPTH-1]`, driven directly from registers with no combinational path from inputs.
- Priority on every rising edge, highest first:
  1. `reset`=1: all `s` = 0, all `v` = 0, `occ` = 0.
  2. `flush`=1: all `s` = 0, all `v` = 0, `occ` = 0, regardless of `en`, `d` and `d_valid`.
  3. `en`=1 (shift):
     - `s[0]` = (`ZERO_BUBBLES` && !`d_valid`) ? 0 : `d`; `v[0]` = `d_valid`.
     - For i ≥ 1: `s[i]` = `s[i-1]`, `v[i]` = `v[i-1]`.
     - `occ` = `occ` + `d_valid` − `v[DEPTH-1]`, using the pre-edge value of `v[DEPTH-1]`.
  4. Otherwise (stall): all state holds.
- Invariant: `occ` always equals popcount(`v`). It never exceeds DEPTH and never underflows; the bench checks this every cycle.
- Entering and leaving on the same edge (`d_valid`=1, `v[DEPTH-1]`=1, `en`=1) leaves `occ` unchanged.
- With `ZERO_BUBBLES`=0, bubble stages carry arbitrary data. Consumers must qualify `q` with `q_valid`.
- `DEPTH`=1 degenerates to `flopr` plus enable, flush and valid. `occ` is then 1 bit wide.

## Timing
- Reset value of every output: `q` = 0, `q_valid` = 0, `occ` = 0. These values are visible after the first rising edge with `reset`=1.
- Reset mid-operation: in-flight entries are discarded on that edge, with no partial drain.
- Latency: an entry presented with `en`=1 at edge k appears on `q` after edge k+DEPTH−1 when `en` stays high. Each stall cycle adds one cycle to the latency.
- Throughput: one entry per enabled cycle; no back-pressure output.
- `flush` and `en` both high: flush wins. The entry on `d` that cycle is dropped.
- `flush` and `reset` both high: reset semantics apply (the two are identical in effect).
- Stall with `d` changing: nothing is captured, and `q`/`q_valid`/`occ` are stable for the whole stall.
- All outputs change only on rising edges of `clk`.

## Test plan
All scenarios use N=10, DEPTH=2, ZERO_BUBBLES=1.

- Reset: hold `reset`=1 for 5 cycles with `d`=10'h3FF and `d_valid`=1 → `q`=0, `q_valid`=0 and `occ`=0 throughout. The first valid `q` appears 2 edges after `reset` falls.
- Streaming: with `en`=1, drive 10 random valid words ds[0..9] on consecutive edges → `q` equals ds[i−2] on edge i for i=2..11; `occ`=1 after the first edge, then 2, staying at 2 while full.
- Stall: fill with 10'h155 then 10'h0AA, then hold `en`=0 for 3 cycles while `d`=10'h3FF → `q`=10'h155 and `occ`=2 stable. After `en` returns to 1: `q`=10'h0AA, then 10'h3FF.
- Flush: with `occ`=2, assert `flush`=1 and `en`=1 together for one cycle with `d`=10'h123 → next edge gives `q`=0, `q_valid`=0, `occ`=0. 10'h123 never appears on `q`.
- Bubbles: alternate `d_valid` 1,0,1,0 with `d`=10'h2AA → `q_valid` sequence 1,0,1,0 delayed by 2 edges; bubble entries show `q`=0; `occ` always matches popcount(`v`).
- Reset mid-stream: assert `reset` for one edge while streaming full → that edge clears `q`, `q_valid` and `occ` to 0, and streaming resumes with 2-edge latency.

Source files
------------

// File: rtl/pipe_regs.sv
// pipe_regs - parametrised multi-stage pipeline register with per-stage
// valid bits, stall, flush and an occupancy counter.
//
// Carries an N-bit word through DEPTH register stages.
// Every stage holds a data word and a valid bit.
// The occupancy counter is kept as a register rather than a popcount of the
// valid bits, so q, q_valid and occ all come straight from flops.
//
// Parameters:
//   N            data width in bits (>= 1)
//   DEPTH        number of register stages (>= 1), latency in enabled cycles
//   ZERO_BUBBLES 1: a stage written with valid=0 stores all-zero data
//                0: a stage written with valid=0 stores d unchanged
//
// Ports:
//   clk      in   rising-edge clock for all state
//   reset    in   synchronous active-high reset
//   en       in   advance enable, 0 stalls every stage
//   flush    in   turn every stage into a bubble, wins over en
//   d        in   input word
//   d_valid  in   d carries a valid entry
//   q        out  word in the last stage
//   q_valid  out  valid bit of the last stage
//   occ      out  registered count of valid stages, 0..DEPTH
module pipe_regs #(
  parameter int N            = 64,
  parameter int DEPTH        = 1,
  parameter int ZERO_BUBBLES = 1,
  localparam int OCC_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [N-1:0]     d,
  input  logic             d_valid,
  output logic [N-1:0]     q,
  output logic             q_valid,
  output logic [OCC_W-1:0] occ
);

  logic [N-1:0]     s_q [DEPTH];
  logic [N-1:0]     s_d [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  // Next-state logic: flush clears everything, en shifts by one stage, and
  // otherwise every stage holds.
  // The counter update uses the pre-edge valid bit of the last stage, so an
  // entry entering while another leaves keeps occ unchanged.
  always_comb begin
    s_d   = s_q;
    v_d   = v_q;
    occ_d = occ_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        s_d[i] = '0;
      end
      v_d   = '0;
      occ_d = '0;
    end else if (en) begin
      s_d[0] = ((ZERO_BUBBLES != 0) && !d_valid) ? '0 : d;
      v_d[0] = d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        s_d[i] = s_q[i-1];
        v_d[i] = v_q[i-1];
      end
      occ_d = occ_q + OCC_W'(d_valid) - OCC_W'(v_q[DEPTH-1]);
    end
  end

  // State registers with synchronous reset.
  // On reset, all in-flight entries are discarded on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        s_q[i] <= '0;
      end
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      s_q   <= s_d;
      v_q   <= v_d;
      occ_q <= occ_d;
    end
  end

  assign q       = s_q[DEPTH-1];
  assign q_valid = v_q[DEPTH-1];
  assign occ     = occ_q;

endmodule

// File: tb/tb_pipe_regs.sv
// tb_pipe_regs - self-checking bench for pipe_regs with N=10, DEPTH=2,
// ZERO_BUBBLES=1.
// The reference model holds the pipeline as a queue of (data, valid) entries.
// An enabled cycle pushes a new entry at the front and drops the oldest one.
// The expected occupancy is the number of valid entries in the queue.
module tb_pipe_regs;

  localparam int N     = 10;
  localparam int DEPTH = 2;
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [N-1:0] data;
    logic         valid;
  } ent_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             flush;
  logic [N-1:0]     d;
  logic             d_valid;
  logic [N-1:0]     q;
  logic             q_valid;
  logic [OCC_W-1:0] occ;

  int   total = 0;
  int   bad   = 0;
  ent_t mq[$];

  pipe_regs #(.N(N), .DEPTH(DEPTH), .ZERO_BUBBLES(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .flush   (flush),
    .d       (d),
    .d_valid (d_valid),
    .q       (q),
    .q_valid (q_valid),
    .occ     (occ)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value differs from
  // the expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic void modelClear();
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back('0);
  endfunction

  function automatic int modelOcc();
    int n = 0;
    foreach (mq[i]) if (mq[i].valid) n++;
    return n;
  endfunction

  // Drives one cycle of inputs and advances the model across the edge.
  // After the edge, it compares every output against the model.
  task automatic applyStimulus(input bit r, input bit e, input bit f,
                               input logic [N-1:0] dd, input bit dv,
                               input string tag);
    ent_t ne;
    reset   = r;
    en      = e;
    flush   = f;
    d       = dd;
    d_valid = dv;
    @(posedge clk);
    if (r || f) begin
      modelClear();
    end else if (e) begin
      ne.valid = dv;
      ne.data  = dv ? dd : '0;
      mq.push_front(ne);
      void'(mq.pop_back());
    end
    #1;
    checkOutput({tag, ".q"},       32'(q),       32'(mq[DEPTH-1].data));
    checkOutput({tag, ".q_valid"}, 32'(q_valid), 32'(mq[DEPTH-1].valid));
    checkOutput({tag, ".occ"},     32'(occ),     32'(modelOcc()));
  endtask

  initial begin
    logic [N-1:0] ds [10];
    reset = 1'b1; en = 1'b0; flush = 1'b0; d = '0; d_valid = 1'b0;
    modelClear();

    // Reset held for five cycles with a valid all-ones word on d.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 10'h3FF, 1'b1, "reset");
      checkOutput("reset.q_zero", 32'(q), 32'h0);
      checkOutput("reset.occ_zero", 32'(occ), 32'h0);
    end

    // Streaming random valid words; q lags d by two edges.
    foreach (ds[i]) ds[i] = N'($urandom);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, (i < 10) ? ds[i] : 10'h000, i < 10, "stream");
      if (i >= 1 && i <= 9) checkOutput("stream.occ_full", 32'(occ), (i == 0) ? 32'd1 : 32'd2);
      if (i >= 1 && i <= 10) checkOutput("stream.q_lag", 32'(q), 32'(ds[i-1]));
    end

    // Stall: fill the pipe, then hold it while d changes.
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h155, 1'b1, "fill");
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h0AA, 1'b1, "fill");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 10'h3FF, 1'b1, "stall");
      checkOutput("stall.q_hold", 32'(q), 32'h155);
      checkOutput("stall.occ_hold", 32'(occ), 32'd2);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h3FF, 1'b1, "resume");
    checkOutput("resume.q1", 32'(q), 32'h0AA);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h3FF, 1'b1, "resume");
    checkOutput("resume.q2", 32'(q), 32'h3FF);

    // Flush together with en drops the word on d.
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h123, 1'b1, "flush");
    checkOutput("flush.q", 32'(q), 32'h0);
    checkOutput("flush.occ", 32'(occ), 32'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 10'h000, 1'b0, "postflush");
      checkOutput("postflush.valid", 32'(q_valid), 32'd0);
    end

    // Bubbles alternating with valid entries.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 10'h2AA, (i < 4) && (i % 2 == 0), "bubble");
    end

    // Reset mid-stream while the pipe is full.
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h011, 1'b1, "midrst");
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h022, 1'b1, "midrst");
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h033, 1'b1, "midrst");
    checkOutput("midrst.occ", 32'(occ), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h044, 1'b1, "midrst");
    checkOutput("midrst.lat1", 32'(q_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h055, 1'b1, "midrst");
    checkOutput("midrst.lat2", 32'(q), 32'h044);

    // Random mix of every control input.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, ($urandom % 4) != 0,
                    $urandom_range(0, 24) == 0, N'($urandom),
                    ($urandom % 3) != 0, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
